disto16x16: RTL and testbench
=============================

DISTO16X16 -- requirements
Module: disto16x16

Interface
REQ-001 SHALL have parameter SHIFT, default 5, the right-shift applied to each 4x4 weighted-transform difference.
REQ-002 SHALL have parameter NUM_BLK, default 16, the number of 4x4 sub-blocks per 16x16 macroblock; it is fixed at 16.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 src  input  2048  16x16 source pixels, 8-bit unsigned; pixel (row,col) at bits 8k+7:8k, k=row*16+col.
REQ-007 rec  input  2048  16x16 reconstructed pixels; same packing as src.
REQ-008 w  input  256  sixteen 16-bit signed weights, weight j at bits 16j+15:16j.
REQ-009 busy  output  1  high from start acceptance until done.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 disto  output  32  unsigned distortion result; held until the next done.
REQ-012 t_start  output  1  one-cycle pulse to the downstream weighted-Hadamard pair.
REQ-013 t_in_a / t_in_b  output  128 each  current 4x4 src / rec block; pixel (r,c) at bits 8(4r+c)+7:8(4r+c).
REQ-014 t_w  output  256  latched w, passed through unchanged.
REQ-015 t_sum_a / t_sum_b  input  32 each  signed weighted sums returned for t_in_a / t_in_b.
REQ-016 t_done  input  1  the sums are valid in this cycle.

Function
REQ-017 SHALL latch src, rec and w in the cycle start is accepted; later input changes SHALL have no effect until the next start.
REQ-018 FSM states: IDLE -> ISSUE on start; ISSUE -> WAIT after one cycle; WAIT -> ACC on t_done; ACC -> ISSUE if blk<15, else -> FIN; FIN -> IDLE after one cycle.
REQ-019 blk is a 4-bit counter; block b covers rows 4*(b/4)..+3 and cols 4*(b%4)..+3 (raster order); blk SHALL clear on start and increment in ACC.
REQ-020 t_start SHALL be high exactly in ISSUE; t_in_a and t_in_b SHALL be stable from ISSUE through WAIT.
REQ-021 In ACC, acc SHALL add |t_sum_a - t_sum_b| >> SHIFT (33-bit signed difference, absolute value, logical shift); acc SHALL wrap modulo 2^32.
REQ-022 In FIN: disto <= acc, done = 1; busy SHALL drop in the same cycle.
REQ-023 Latency: with downstream latency L (t_done L cycles after t_start) and start sampled at cycle 0, done SHALL be high at cycle 16*(L+2)+1, which is 65 for L=2.
REQ-024 start while busy SHALL be ignored, not queued; t_done outside WAIT SHALL be ignored.
REQ-025 The block SHALL not time out; it waits in WAIT indefinitely.

Reset
REQ-026 rst_n low SHALL force IDLE, blk=0, acc=0, disto=0, done=0, busy=0, t_start=0, and clear the latched data, including mid-operation; no done SHALL follow for an aborted run.

Configuration
REQ-027 Macro DISTO16X16_TLAMBDA_EN, when defined: adds input tlambda [15:0] (unsigned, latched at start) and a registered stage after FIN giving disto = low 32 bits of (tlambda*acc + 128) >> 8.
REQ-028 With the macro defined, done SHALL come one cycle later than REQ-023; without it, the port is absent and disto = acc.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the pixel width (8), the sum width (32), SHIFT default and NUM_BLK.
REQ-030 One sub-module, disto_blk_sel, SHALL map (src, rec, blk) to (t_in_a, t_in_b) combinationally.

Verification
REQ-031 src = rec = random, w all 1, L=2 model -> disto = 0; done at cycle 65; t_start exactly 16 pulses.
REQ-032 src all 0; rec all 0 except pixel (0,0)=255; w all 1 -> block 0 sums 0 vs 4080; disto = 127.
REQ-033 Stub returns t_sum_a=1000, t_sum_b=-1000 per block -> disto = 16*62 = 992.
REQ-034 start re-pulsed at cycles 10 and 40 of a run -> ignored; a single done; result unchanged.
REQ-035 rst_n asserted while in WAIT of block 7 -> all outputs 0 immediately; a later start completes normally.
REQ-036 With DISTO16X16_TLAMBDA_EN, tlambda=256 and the REQ-032 stimulus -> disto = 127; done at cycle 66.

Source files
------------

// File: rtl/disto16x16_pkg.sv
// Shared types and constants for the 16x16 weighted-transform distortion engine.
package disto16x16_pkg;

    localparam int unsigned PixWidth     = 8;
    localparam int unsigned SumWidth     = 32;
    localparam int unsigned ShiftDefault = 5;
    localparam int unsigned NumBlk       = 16;
    localparam int unsigned ImgBits      = 16 * 16 * PixWidth;
    localparam int unsigned BlkBits      = 4 * 4 * PixWidth;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAcc,
        StFin
    } state_e;

endpackage

// File: rtl/disto_blk_sel.sv
// Extracts the 4x4 src/rec sub-block selected by blk (raster order) from the 16x16 images.
module disto_blk_sel
    import disto16x16_pkg::*;
(
    input  logic [ImgBits-1:0] src,
    input  logic [ImgBits-1:0] rec,
    input  logic [3:0]         blk,
    output logic [BlkBits-1:0] t_in_a,
    output logic [BlkBits-1:0] t_in_b
);

    always_comb begin
        int k;
        k      = 0;
        t_in_a = '0;
        t_in_b = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                // blk[3:2] selects the block row, blk[1:0] the block column
                k = (int'(blk[3:2]) * 4 + r) * 16 + int'(blk[1:0]) * 4 + c;
                t_in_a[PixWidth*(4*r+c) +: PixWidth] = src[PixWidth*k +: PixWidth];
                t_in_b[PixWidth*(4*r+c) +: PixWidth] = rec[PixWidth*k +: PixWidth];
            end
        end
    end

endmodule

// File: rtl/disto16x16.sv
// 16x16 macroblock distortion: issues 16 sub-blocks to an external weighted-Hadamard pair
// and accumulates |sum_a - sum_b| >> SHIFT. Optional lambda scaling via DISTO16X16_TLAMBDA_EN.
module disto16x16
    import disto16x16_pkg::*;
#(
    parameter int unsigned SHIFT   = ShiftDefault,
    parameter int unsigned NUM_BLK = NumBlk
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ImgBits-1:0]  src,
    input  logic [ImgBits-1:0]  rec,
    input  logic [255:0]        w,
`ifdef DISTO16X16_TLAMBDA_EN
    input  logic [15:0]         tlambda,
`endif
    output logic                busy,
    output logic                done,
    output logic [31:0]         disto,
    output logic                t_start,
    output logic [BlkBits-1:0]  t_in_a,
    output logic [BlkBits-1:0]  t_in_b,
    output logic [255:0]        t_w,
    input  logic [SumWidth-1:0] t_sum_a,
    input  logic [SumWidth-1:0] t_sum_b,
    input  logic                t_done
);

    state_e             state_q;
    logic [ImgBits-1:0] src_q, rec_q;
    logic [255:0]       w_q;
    logic [3:0]         blk_q;
    logic [31:0]        acc_q, term_q, disto_q;
    logic               busy_q, done_q, t_start_q;

    logic signed [SumWidth:0] diff;
    logic        [SumWidth:0] mag;
    logic        [31:0]       term_d, acc_sum;
    logic                     last_blk;

    // Sign-extend to 33 bits so the difference of two 32-bit signed sums cannot overflow
    assign diff     = $signed({t_sum_a[SumWidth-1], t_sum_a}) - $signed({t_sum_b[SumWidth-1], t_sum_b});
    assign mag      = diff[SumWidth] ? 33'(-diff) : 33'(diff);
    assign term_d   = 32'(mag >> SHIFT);
    assign acc_sum  = acc_q + term_q;
    assign last_blk = (blk_q == 4'(NUM_BLK - 1));

`ifdef DISTO16X16_TLAMBDA_EN
    logic [15:0] tlambda_q;
    logic [31:0] scaled;
    assign scaled = 32'((49'(tlambda_q) * 49'(acc_q) + 49'd128) >> 8);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            src_q     <= '0;
            rec_q     <= '0;
            w_q       <= '0;
            blk_q     <= '0;
            acc_q     <= '0;
            term_q    <= '0;
            disto_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            t_start_q <= 1'b0;
`ifdef DISTO16X16_TLAMBDA_EN
            tlambda_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q     <= src;
                        rec_q     <= rec;
                        w_q       <= w;
                        blk_q     <= '0;
                        acc_q     <= '0;
                        busy_q    <= 1'b1;
                        t_start_q <= 1'b1;
                        state_q   <= StIssue;
`ifdef DISTO16X16_TLAMBDA_EN
                        tlambda_q <= tlambda;
`endif
                    end
                end
                StIssue: begin
                    t_start_q <= 1'b0;
                    state_q   <= StWait;
                end
                StWait: begin
                    // Sums are only valid while t_done is high, so capture the term here
                    if (t_done) begin
                        term_q  <= term_d;
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    acc_q <= acc_sum;
                    blk_q <= blk_q + 4'd1;
                    if (last_blk) begin
                        state_q <= StFin;
`ifndef DISTO16X16_TLAMBDA_EN
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        disto_q <= acc_sum;
`endif
                    end else begin
                        t_start_q <= 1'b1;
                        state_q   <= StIssue;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
`ifdef DISTO16X16_TLAMBDA_EN
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    disto_q <= scaled;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    disto_blk_sel u_blk_sel (
        .src    (src_q),
        .rec    (rec_q),
        .blk    (blk_q),
        .t_in_a (t_in_a),
        .t_in_b (t_in_b)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign disto   = disto_q;
    assign t_start = t_start_q;
    assign t_w     = w_q;

endmodule

// File: tb/tb_disto16x16.sv
// Self-checking bench for disto16x16 with a behavioural weighted-Hadamard stub.
module tb_disto16x16;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [2047:0] src, rec;
    logic [255:0]  w;
`ifdef DISTO16X16_TLAMBDA_EN
    logic [15:0]   tlambda;
`endif
    logic          busy, done, t_start, t_done;
    logic [31:0]   disto, t_sum_a, t_sum_b;
    logic [127:0]  t_in_a, t_in_b;
    logic [255:0]  t_w;

    always #5 clk = ~clk;

    disto16x16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .src     (src),
        .rec     (rec),
        .w       (w),
`ifdef DISTO16X16_TLAMBDA_EN
        .tlambda (tlambda),
`endif
        .busy    (busy),
        .done    (done),
        .disto   (disto),
        .t_start (t_start),
        .t_in_a  (t_in_a),
        .t_in_b  (t_in_b),
        .t_w     (t_w),
        .t_sum_a (t_sum_a),
        .t_sum_b (t_sum_b),
        .t_done  (t_done)
    );

    int            n_total = 0;
    int            n_bad = 0;
    int            stub_mode = 2;
    int            stub_lat = 2;
    int            stub_blk = 0;
    longint        model_acc = 0;
    logic [2047:0] exp_src, exp_rec;
    logic [255:0]  exp_w;
    logic [15:0]   exp_tl = 16'd256;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk_of(input logic [2047:0] img, input int b);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(4*r+c) +: 8] = img[8*((4*(b/4)+r)*16 + 4*(b%4)+c) +: 8];
        return o;
    endfunction

    // Weighted sum of absolute 4x4 Walsh-Hadamard coefficients, coefficient j = 4u+v
    function automatic int hsum(input logic [127:0] b, input logic [255:0] wv);
        int s, cf, sg;
        s = 0;
        for (int u = 0; u < 4; u++)
            for (int v = 0; v < 4; v++) begin
                cf = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        sg = (($countones(u & r) + $countones(v & c)) % 2 == 1) ? -1 : 1;
                        cf += sg * int'(b[8*(4*r+c) +: 8]);
                    end
                if (cf < 0) cf = -cf;
                s += int'($signed(wv[16*(4*u+v) +: 16])) * cf;
            end
        return s;
    endfunction

    function automatic longint expected_disto(input longint acc);
`ifdef DISTO16X16_TLAMBDA_EN
        return ((longint'(exp_tl) * acc + 128) >> 8) & 64'hFFFF_FFFF;
`else
        return acc;
`endif
    endfunction

    // Downstream stub: answers each t_start after stub_lat cycles; the model accumulates
    // |a-b|>>5 of whatever it returns.
    initial begin
        logic [31:0] sa, sb;
        longint      d;
        t_done  = 1'b0;
        t_sum_a = '0;
        t_sum_b = '0;
        forever begin
            @(posedge clk); #1;
            if (t_start) begin
                if (stub_mode == 0) begin
                    check_eq($sformatf("blk%0d_in_a", stub_blk), t_in_a, blk_of(exp_src, stub_blk));
                    check_eq($sformatf("blk%0d_in_b", stub_blk), t_in_b, blk_of(exp_rec, stub_blk));
                    sa = hsum(t_in_a, t_w);
                    sb = hsum(t_in_b, t_w);
                end else if (stub_mode == 1) begin
                    sa = 32'd1000;
                    sb = -32'sd1000;
                end else begin
                    sa = $urandom;
                    sb = $urandom;
                end
                d = longint'($signed(sa)) - longint'($signed(sb));
                if (d < 0) d = -d;
                model_acc = (model_acc + (d >> 5)) & 64'hFFFF_FFFF;
                stub_blk++;
                repeat (stub_lat) @(posedge clk);
                #1;
                t_done  = 1'b1;
                t_sum_a = sa;
                t_sum_b = sb;
                @(posedge clk); #1;
                t_done  = 1'b0;
                t_sum_a = $urandom;
                t_sum_b = $urandom;
            end
        end
    end

    task automatic pulse_start();
        exp_src   = src;
        exp_rec   = rec;
        exp_w     = w;
        stub_blk  = 0;
        model_acc = 0;
`ifdef DISTO16X16_TLAMBDA_EN
        exp_tl = tlambda;
`endif
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // fixed_exp < 0 means the model value is used
    task automatic run_once(input int lat, input int mode, input bit scramble, input bit repulse,
                            input string tag, input longint fixed_exp);
        int     cyc, ts_cnt, exp_lat, extra;
        bit     got;
        longint exp_d;
        stub_lat  = lat;
        stub_mode = mode;
        pulse_start();
        check_eq({tag, "_t_w"}, t_w, exp_w);
        check_eq({tag, "_busy"}, busy, 1'b1);
        if (scramble) begin
            for (int i = 0; i < 64; i++) begin
                src[32*i +: 32] = $urandom;
                rec[32*i +: 32] = $urandom;
            end
            for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        end
        cyc = 1; ts_cnt = 0; got = 1'b0;
        while (cyc < 4000) begin
            if (t_start) ts_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (repulse) start = (cyc == 10 || cyc == 40);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
`ifdef DISTO16X16_TLAMBDA_EN
        extra = 1;
`else
        extra = 0;
`endif
        exp_lat = 16 * (lat + 2) + 1 + extra;
        exp_d   = (fixed_exp >= 0) ? fixed_exp : expected_disto(model_acc);
        check_eq({tag, "_done_seen"}, got, 1'b1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        check_eq({tag, "_t_start_cnt"}, ts_cnt, 16);
        check_eq({tag, "_busy_at_done"}, busy, 1'b0);
        check_eq({tag, "_disto"}, disto, exp_d[31:0]);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_disto_held"}, disto, exp_d[31:0]);
        if (repulse) begin
            got = 1'b0;
            repeat (100) begin
                @(posedge clk); #1;
                if (done || busy) got = 1'b1;
            end
            check_eq({tag, "_no_second_done"}, got, 1'b0);
        end
    endtask

    task automatic abort_run();
        int cyc, ts_cnt;
        bit seen;
        stub_lat  = 3;
        stub_mode = 2;
        pulse_start();
        cyc = 1; ts_cnt = 0;
        while (ts_cnt < 8 && cyc < 500) begin
            if (t_start) ts_cnt++;
            if (ts_cnt < 8) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        check_eq("abort_reached_blk7", ts_cnt, 8);
        check_eq("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_disto", disto, 32'd0);
        check_eq("abort_t_start", t_start, 1'b0);
        check_eq("abort_t_in_a", t_in_a, 128'd0);
        check_eq("abort_t_in_b", t_in_b, 128'd0);
        check_eq("abort_t_w", t_w, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check_eq("abort_no_done", seen, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        src   = '0;
        rec   = '0;
        w     = '0;
`ifdef DISTO16X16_TLAMBDA_EN
        tlambda = 16'd256;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_disto", disto, 32'd0);
        check_eq("rst_t_start", t_start, 1'b0);
        check_eq("rst_t_in_a", t_in_a, 128'd0);
        check_eq("rst_t_w", t_w, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) src[32*i +: 32] = $urandom;
        rec = src;
        for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'd1;
        run_once(2, 0, 1'b1, 1'b0, "equal", 0);

        src = '0;
        rec = '0;
        rec[7:0] = 8'hFF;
        for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'd1;
        run_once(2, 0, 1'b0, 1'b0, "one_pixel", 127);

        run_once(2, 1, 1'b0, 1'b0, "const_sums", 992);
        run_once(2, 1, 1'b0, 1'b1, "repulse", 992);

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 64; i++) begin
                src[32*i +: 32] = $urandom;
                rec[32*i +: 32] = $urandom;
            end
            for (int j = 0; j < 16; j++) w[16*j +: 16] = 16'($urandom_range(0, 200)) - 16'd100;
`ifdef DISTO16X16_TLAMBDA_EN
            tlambda = 16'($urandom);
`endif
            run_once(int'($urandom_range(1, 4)), (n % 2 == 0) ? 0 : 2, 1'b1, 1'b0,
                     $sformatf("rand%0d", n), -1);
        end

        abort_run();
`ifdef DISTO16X16_TLAMBDA_EN
        tlambda = 16'd256;
`endif
        run_once(2, 1, 1'b0, 1'b0, "after_abort", 992);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
